// File: rtl/shift194_load_sequencer_if.sv
// Fetch-side handshake between the graphics ROM fetch logic (master) and the
// 194 load sequencer (slave). Plane p occupies fetch_data[4p+3:4p], D0 at the LSB.
interface shift194_load_sequencer_if #(
  parameter int PLANES = 3
);
  logic [4*PLANES-1:0] fetch_data;
  logic                fetch_vld;
  logic                fetch_rdy;

  modport master (output fetch_data, output fetch_vld, input fetch_rdy);
  modport slave  (input fetch_data, input fetch_vld, output fetch_rdy);
endinterface

// File: rtl/shift194_load_sequencer.sv
// shift194_load_sequencer
// Buffers parallel bitplane words from the ROM fetch path and drives a bank of
// 74194-style 4-bit shift registers: one load per 4-pixel group, then three
// shifts whose direction is latched from flip at load time.
// Optional feature: define SHIFT194_UNDERRUN_CNT_EN to add the saturating
// 8-bit underrun_cnt output; without it only the sticky underrun flag exists.
module shift194_load_sequencer #(
  parameter int PLANES     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     CP,
  input  logic                     Reset,
  input  logic                     enable,
  input  logic                     pix_ce,
  input  logic                     flip,
  shift194_load_sequencer_if.slave fetch,
  output logic                     sh_S0,
  output logic                     sh_S1,
  output logic                     sh_cen,
  output logic                     sh_cr_n,
  output logic [4*PLANES-1:0]      sh_d,
  output logic                     underrun
`ifdef SHIFT194_UNDERRUN_CNT_EN
  ,
  output logic [7:0]               underrun_cnt
`endif
);

  localparam int DW = 4 * PLANES;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   fifo_q [FIFO_DEPTH];
  logic [DW-1:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [1:0]      pix_cnt_q, pix_cnt_d;
  logic            dir_q, dir_d;
  logic            s0_q, s0_d;
  logic            s1_q, s1_d;
  logic            cen_q, cen_d;
  logic            cr_n_q, cr_n_d;
  logic [DW-1:0]   d_q, d_d;
  logic            underrun_q, underrun_d;
`ifdef SHIFT194_UNDERRUN_CNT_EN
  logic [7:0]      urun_cnt_q, urun_cnt_d;
`endif

  logic            full_s;
  logic            empty_s;
  logic            fetch_rdy_s;
  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  logic [DW-1:0]   head_s;

  assign full_s      = (occ_q == CW'(FIFO_DEPTH));
  assign empty_s     = (occ_q == {CW{1'b0}});
  // The buffer only accepts data once the sequencer has left IDLE.
  assign fetch_rdy_s = !full_s && (state_q != ST_IDLE);
  assign push_s      = fetch.fetch_vld && fetch_rdy_s;
  assign head_s      = fifo_q[rd_ptr_q];

  // Sequencer next-state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    dir_d      = dir_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    cen_d      = 1'b0;
    cr_n_d     = cr_n_q;
    d_d        = d_q;
    underrun_d = underrun_q;
    pop_s      = 1'b0;
    flush_s    = 1'b0;
`ifdef SHIFT194_UNDERRUN_CNT_EN
    urun_cnt_d = urun_cnt_q;
`endif
    if (!enable) begin
      // Dropping enable abandons the group in flight and clears the bank.
      state_d    = ST_IDLE;
      flush_s    = 1'b1;
      cr_n_d     = 1'b0;
      s0_d       = 1'b0;
      s1_d       = 1'b0;
      d_d        = {DW{1'b0}};
      underrun_d = 1'b0;
      pix_cnt_d  = 2'd0;
`ifdef SHIFT194_UNDERRUN_CNT_EN
      urun_cnt_d = 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          flush_s = 1'b1;
          cr_n_d  = 1'b1;
`ifdef SHIFT194_UNDERRUN_CNT_EN
          urun_cnt_d = 8'd0;
`endif
        end
        ST_PRIME: begin
          cr_n_d = 1'b1;
          if (!empty_s) begin
            state_d   = ST_RUN;
            pix_cnt_d = 2'd0;
          end else begin
            state_d = ST_PRIME;
          end
        end
        ST_RUN: begin
          cr_n_d = 1'b1;
          if (pix_ce) begin
            pix_cnt_d = pix_cnt_q + 2'd1;
            if (pix_cnt_q == 2'd0) begin
              if (!empty_s) begin
                pop_s = 1'b1;
                d_d   = head_s;
                s1_d  = 1'b1;
                s0_d  = 1'b1;
                dir_d = flip;
                cen_d = 1'b1;
              end else begin
                // Nothing to load: blank this group and flag it.
                cr_n_d     = 1'b0;
                underrun_d = 1'b1;
`ifdef SHIFT194_UNDERRUN_CNT_EN
                if (urun_cnt_q != 8'hFF) begin
                  urun_cnt_d = urun_cnt_q + 8'd1;
                end else begin
                  urun_cnt_d = urun_cnt_q;
                end
`endif
              end
            end else begin
              // dir 0 -> shift right (01), dir 1 -> shift left (10).
              s1_d  = dir_q;
              s0_d  = !dir_q;
              cen_d = 1'b1;
            end
          end else begin
            pix_cnt_d = pix_cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          flush_s = 1'b1;
          cr_n_d  = 1'b0;
        end
      endcase
    end
  end

  // Fetch buffer bookkeeping: storage write, pointers and occupancy.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_s) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      occ_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_d[wr_ptr_q] = fetch.fetch_data;
        wr_ptr_d         = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + CW'(1'b1);
        2'b01:   occ_d = occ_q - CW'(1'b1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State, buffer and output registers; Reset clears everything immediately.
  always_ff @(posedge CP or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      occ_q      <= {CW{1'b0}};
      pix_cnt_q  <= 2'd0;
      dir_q      <= 1'b0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      cen_q      <= 1'b0;
      cr_n_q     <= 1'b0;
      d_q        <= {DW{1'b0}};
      underrun_q <= 1'b0;
`ifdef SHIFT194_UNDERRUN_CNT_EN
      urun_cnt_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pix_cnt_q  <= pix_cnt_d;
      dir_q      <= dir_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      cen_q      <= cen_d;
      cr_n_q     <= cr_n_d;
      d_q        <= d_d;
      underrun_q <= underrun_d;
`ifdef SHIFT194_UNDERRUN_CNT_EN
      urun_cnt_q <= urun_cnt_d;
`endif
    end
  end

  assign fetch.fetch_rdy = fetch_rdy_s;
  assign sh_S0           = s0_q;
  assign sh_S1           = s1_q;
  assign sh_cen          = cen_q;
  assign sh_cr_n         = cr_n_q;
  assign sh_d            = d_q;
  assign underrun        = underrun_q;
`ifdef SHIFT194_UNDERRUN_CNT_EN
  assign underrun_cnt    = urun_cnt_q;
`endif

endmodule

// File: tb/tb_shift194_load_sequencer.sv
// Self-checking bench for shift194_load_sequencer: directed scenarios followed
// by randomized traffic, every cycle compared against a queue-based reference.
module tb_shift194_load_sequencer;

  localparam int PLANES = 3;
  localparam int DEPTH  = 2;
  localparam int DW     = 4 * PLANES;
  localparam int VW     = DW + 6;

  logic          CP;
  logic          Reset;
  logic          enable;
  logic          pix_ce;
  logic          flip;
  logic          sh_S0, sh_S1, sh_cen, sh_cr_n, underrun;
  logic [DW-1:0] sh_d;
`ifdef SHIFT194_UNDERRUN_CNT_EN
  logic [7:0]    underrun_cnt;
`endif

  shift194_load_sequencer_if #(.PLANES(PLANES)) bus ();

  shift194_load_sequencer #(.PLANES(PLANES), .FIFO_DEPTH(DEPTH)) dut (
    .CP           (CP),
    .Reset        (Reset),
    .enable       (enable),
    .pix_ce       (pix_ce),
    .flip         (flip),
    .fetch        (bus),
    .sh_S0        (sh_S0),
    .sh_S1        (sh_S1),
    .sh_cen       (sh_cen),
    .sh_cr_n      (sh_cr_n),
    .sh_d         (sh_d),
    .underrun     (underrun)
`ifdef SHIFT194_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = priming, 2 = running.
  int            m_mode;
  logic [DW-1:0] m_q[$];
  int            m_pix;
  logic          m_dir, m_s1, m_s0, m_cen, m_crn, m_urun;
  logic [DW-1:0] m_d;
`ifdef SHIFT194_UNDERRUN_CNT_EN
  int            m_ucnt;
`endif

  task automatic model_reset();
    m_mode = 0; m_q.delete(); m_pix = 0; m_dir = 1'b0;
    m_s1 = 1'b0; m_s0 = 1'b0; m_cen = 1'b0; m_crn = 1'b0; m_urun = 1'b0; m_d = '0;
`ifdef SHIFT194_UNDERRUN_CNT_EN
    m_ucnt = 0;
`endif
  endtask

  function automatic logic model_rdy();
    return (m_mode != 0) && (m_q.size() < DEPTH);
  endfunction

  task automatic model_step();
    logic          push;
    logic [DW-1:0] pdata;
    int            occ;
    push  = bus.fetch_vld && model_rdy();
    pdata = bus.fetch_data;
    occ   = m_q.size();
    m_cen = 1'b0;
    if (!enable) begin
      m_mode = 0; m_q.delete(); push = 1'b0;
      m_crn = 1'b0; m_s1 = 1'b0; m_s0 = 1'b0; m_d = '0; m_urun = 1'b0; m_pix = 0;
`ifdef SHIFT194_UNDERRUN_CNT_EN
      m_ucnt = 0;
`endif
    end else if (m_mode == 0) begin
      m_mode = 1; m_crn = 1'b1;
    end else if (m_mode == 1) begin
      m_crn = 1'b1;
      if (occ > 0) begin m_mode = 2; m_pix = 0; end
    end else begin
      m_crn = 1'b1;
      if (pix_ce) begin
        if (m_pix == 0) begin
          if (occ > 0) begin
            m_d = m_q.pop_front(); {m_s1, m_s0} = 2'b11; m_dir = flip; m_cen = 1'b1;
          end else begin
            m_crn = 1'b0; m_urun = 1'b1;
`ifdef SHIFT194_UNDERRUN_CNT_EN
            if (m_ucnt < 255) m_ucnt++;
`endif
          end
        end else begin
          {m_s1, m_s0} = m_dir ? 2'b10 : 2'b01;
          m_cen = 1'b1;
        end
        m_pix = (m_pix + 1) % 4;
      end
    end
    if (push) m_q.push_back(pdata);
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.fetch_rdy, sh_S1, sh_S0, sh_cen, sh_cr_n, underrun, sh_d};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {model_rdy(), m_s1, m_s0, m_cen, m_crn, m_urun, m_d};
  endfunction

  // One clock: model and DUT both advance on the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge CP);
    model_step();
    #1;
    chk("cycle", 32'(dut_vec()), 32'(exp_vec()));
`ifdef SHIFT194_UNDERRUN_CNT_EN
    chk("ucnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
  endtask

  logic [DW-1:0] x, y, z;
  logic          prev_ce;
  int            vld_pct;

  initial begin
    Reset = 1'b0; enable = 1'b0; pix_ce = 1'b0; flip = 1'b0;
    bus.fetch_vld = 1'b0; bus.fetch_data = '0;
    model_reset();
    #2 Reset = 1'b1;
    #1 chk("reset_outs", 32'(dut_vec()), 32'd0);
    @(posedge CP); #1 Reset = 1'b0;

    // Prime with two words, eight strobes every second CP.
    enable = 1'b1; tick();
    bus.fetch_vld = 1'b1; bus.fetch_data = 12'h321; tick();
    bus.fetch_data = 12'h654; tick();
    bus.fetch_vld = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      pix_ce = 1'b1; tick();
      chk("t1_cen", 32'(sh_cen), 32'd1);
      if (s == 1 || s == 5) begin
        chk("t1_load_s", 32'({sh_S1, sh_S0}), 32'd3);
        chk("t1_load_d", 32'(sh_d), (s == 1) ? 32'h321 : 32'h654);
      end else begin
        chk("t1_shift_s", 32'({sh_S1, sh_S0}), 32'd1);
      end
      pix_ce = 1'b0; tick();
    end

    // flip latched at load; a mid-group change waits for the next load.
    x = 12'(($urandom)); y = 12'(($urandom));
    bus.fetch_vld = 1'b1; bus.fetch_data = x; tick();
    bus.fetch_data = y; tick();
    bus.fetch_vld = 1'b0;
    flip = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      pix_ce = 1'b1; tick();
      if (s == 1 || s == 5) begin
        chk("t2_load_s", 32'({sh_S1, sh_S0}), 32'd3);
        chk("t2_load_d", 32'(sh_d), (s == 1) ? 32'(x) : 32'(y));
      end else begin
        chk("t2_shift_s", 32'({sh_S1, sh_S0}), (s < 5) ? 32'd2 : 32'd1);
      end
      if (s == 2) flip = 1'b0;
      pix_ce = 1'b0; tick();
    end

    // Load strobe with an empty buffer.
    pix_ce = 1'b1; tick();
    chk("t3_crn", 32'(sh_cr_n), 32'd0);
    chk("t3_urun", 32'(underrun), 32'd1);
    chk("t3_cen", 32'(sh_cen), 32'd0);
`ifdef SHIFT194_UNDERRUN_CNT_EN
    chk("t3_ucnt", 32'(underrun_cnt), 32'd1);
`endif
    pix_ce = 1'b0; tick();
    chk("t3_crn_back", 32'(sh_cr_n), 32'd1);
    for (int s = 2; s <= 4; s++) begin
      pix_ce = 1'b1; tick();
      chk("t3_advance", 32'({sh_cen, sh_S1, sh_S0}), 32'h5);
      pix_ce = 1'b0; tick();
    end

    // Fill to full with fetch_vld held, then pop at full and refill.
    x = 12'(($urandom)); y = 12'(($urandom)); z = 12'(($urandom));
    bus.fetch_vld = 1'b1; bus.fetch_data = x; tick();
    bus.fetch_data = y; tick();
    bus.fetch_data = z; tick();
    chk("t4_full_rdy", 32'(bus.fetch_rdy), 32'd0);
    pix_ce = 1'b1; tick();
    chk("t4_pop_d", 32'(sh_d), 32'(x));
    chk("t4_pop_rdy", 32'(bus.fetch_rdy), 32'd1);
    pix_ce = 1'b0; tick();
    chk("t4_refill_rdy", 32'(bus.fetch_rdy), 32'd0);
    bus.fetch_vld = 1'b0;
    for (int s = 2; s <= 9; s++) begin
      pix_ce = 1'b1; tick();
      if (s == 5) chk("t4_order_y", 32'(sh_d), 32'(y));
      if (s == 9) chk("t4_order_z", 32'(sh_d), 32'(z));
      pix_ce = 1'b0; tick();
    end

    // enable falls mid-group.
    pix_ce = 1'b1; tick();
    pix_ce = 1'b0; enable = 1'b0; tick();
    chk("t5_crn", 32'(sh_cr_n), 32'd0);
    chk("t5_urun", 32'(underrun), 32'd0);
    chk("t5_rdy", 32'(bus.fetch_rdy), 32'd0);
    chk("t5_cen", 32'(sh_cen), 32'd0);
    enable = 1'b1; tick();
    chk("t5_prime_rdy", 32'(bus.fetch_rdy), 32'd1);

    // Asynchronous reset while sh_cen is high.
    bus.fetch_vld = 1'b1; bus.fetch_data = 12'(($urandom)); tick();
    bus.fetch_vld = 1'b0; tick();
    pix_ce = 1'b1; tick();
    chk("t6_cen_before", 32'(sh_cen), 32'd1);
    #2 Reset = 1'b1;
    #1 chk("t6_async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    pix_ce = 1'b0;
    @(posedge CP); #1 Reset = 1'b0;

    // Randomized traffic.
    prev_ce = 1'b0;
    vld_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) vld_pct = int'($urandom_range(5, 90));
      enable        = ($urandom_range(0, 149) != 0);
      bus.fetch_vld = ($urandom_range(0, 99) < vld_pct);
      bus.fetch_data = 12'(($urandom));
      flip          = 1'($urandom_range(0, 1));
      pix_ce        = prev_ce ? 1'b0 : ($urandom_range(0, 2) != 0);
      prev_ce       = pix_ce;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
